decoder_stream_encoder: RTL and testbench

Sequential 32-to-5 encoder: the inverse of the existing 5-to-32 `decoder` block. It accepts a 32-bit request word over a valid/ready handshake. It then emits, one per handshake, the 5-bit index of every set bit, lowest index first. It is intended as a round-trip partner of `decoder` in the MIPS datapath/bench (for example, register-mask to register-number conversion).

---
 rtl/decoder_stream_pkg.sv | 11 +
 rtl/decoder_stream_encoder_if.sv | 24 ++
 rtl/decoder_stream_encoder_ffs_lsb.sv | 16 +
 rtl/decoder_stream_encoder.sv | 71 +++++++
 tb/tb_decoder_stream_encoder.sv | 124 ++++++++++++
 5 files changed

// File: rtl/decoder_stream_pkg.sv
// decoder_stream_pkg: shared defaults, FSM states and helpers for decoder_stream_encoder.
package decoder_stream_pkg;
    localparam int WIDTH_DEFAULT = 32;
    localparam int IDX_W_DEFAULT = 5;

    typedef enum logic {IDLE, EMIT} enc_state_t;

    function automatic logic is_onehot(input logic [WIDTH_DEFAULT-1:0] w);
        return (w != '0) && ((w & (w - WIDTH_DEFAULT'(1))) == '0);
    endfunction
endpackage

// File: rtl/decoder_stream_encoder_if.sv
// decoder_stream_encoder_if: request-word input stream and index output stream.
interface decoder_stream_encoder_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_word;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_zero;
    logic             busy;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_zero, busy
    );
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_zero, busy
    );
endinterface

// File: rtl/decoder_stream_encoder_ffs_lsb.sv
// ffs_lsb: find-first-set priority scan, bit 0 has highest priority.
module ffs_lsb #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    always_comb begin
        idx   = '0;
        found = |vec;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
    end
endmodule

// File: rtl/decoder_stream_encoder.sv
// decoder_stream_encoder: emits the index of every set bit of a captured word, LSB first.
// Optional ENCODER_ONEHOT_CHECK_EN adds a sticky onehot_err flag for non-one-hot captures.
module decoder_stream_encoder
    import decoder_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input logic clk,
    input logic rst,
    decoder_stream_encoder_if.slave bus
`ifdef ENCODER_ONEHOT_CHECK_EN
    ,
    output logic onehot_err
`endif
);
    enc_state_t       state, state_n;
    logic [WIDTH-1:0] pending, pending_n;
    logic             zero_flag, zero_n;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic             capture;

    ffs_lsb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_ffs (.vec(pending), .idx(idx), .found(found));

    assign capture       = (state == IDLE) && bus.in_valid;
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.busy      = (state == EMIT);
    assign bus.out_idx   = idx;
    assign bus.out_zero  = zero_flag;
    // pending is zero outside EMIT, so found gates the single-bit test there
    assign bus.out_last  = zero_flag | (found && ((pending & (pending - WIDTH'(1))) == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            zero_flag <= zero_n;
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        zero_n    = zero_flag;
        if (capture) begin
            state_n   = EMIT;
            pending_n = bus.in_word;
            zero_n    = (bus.in_word == '0);
        end else if (state == EMIT && bus.out_ready) begin
            pending_n = pending & ~(WIDTH'(1) << idx);
            if (bus.out_last) begin
                state_n   = IDLE;
                pending_n = '0;
                zero_n    = 1'b0;
            end
        end
    end

`ifdef ENCODER_ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) onehot_err <= 1'b0;
        else if (capture && !is_onehot(WIDTH_DEFAULT'(bus.in_word))) onehot_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_decoder_stream_encoder.sv
// tb_decoder_stream_encoder: randomized bench against a bit-list reference model.
module tb_decoder_stream_encoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    decoder_stream_encoder_if #(.WIDTH(32), .IDX_W(5)) bus ();
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic onehot_err;
`endif

    decoder_stream_encoder dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ENCODER_ONEHOT_CHECK_EN
        ,
        .onehot_err(onehot_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one word; out_ready is held low for hold cycles, then random stalls at stall_pct percent.
    task automatic do_word(input logic [31:0] w, input int hold, input int stall_pct);
        int exp_q[$];
        int beat = 0;
        int guard = 0;
        int cyc = 0;
        for (int i = 0; i < 32; i++)
            if (w[i]) exp_q.push_back(i);
        if (exp_q.size() == 0) exp_q.push_back(0);
        @(negedge clk);
        chk("idle_ready", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        bus.in_valid  = 1'b1;
        bus.in_word   = w;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = $urandom_range(1);
        bus.in_word  = $urandom;
        while (beat < exp_q.size() && guard < 400) begin
            guard++;
            bus.out_ready = (cyc >= hold) && ($urandom_range(99) >= stall_pct);
            cyc++;
            chk("emit_status", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b011);
            chk("idx", 32'(bus.out_idx), 32'(exp_q[beat]));
            chk("last", 32'(bus.out_last), 32'(beat == exp_q.size() - 1));
            chk("zero", 32'(bus.out_zero), 32'(w == 0));
            if (bus.out_ready) beat++;
            @(negedge clk);
        end
        if (guard >= 400) chk("drain_timeout", 32'(beat), 32'(exp_q.size()));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("after_last", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_state", {26'd0, bus.in_ready, bus.out_valid, bus.busy, bus.out_last, bus.out_zero, 1'b0},
            32'b100000);
        chk("reset_idx", 32'(bus.out_idx), 32'd0);

        do_word(32'h0000_0001, 0, 0);
        do_word(32'h8000_0012, 0, 0);
        do_word(32'h0000_0000, 0, 0);
        do_word(32'h0000_0300, 3, 0);
        do_word(32'h8000_0000, 0, 0);
        do_word(32'hFFFF_FFFF, 0, 20);
        for (int k = 0; k < 25; k++) begin
            logic [31:0] w;
            w = $urandom;
            if (k % 3 == 1) w = w & $urandom & $urandom;
            do_word(w, $urandom_range(2), $urandom_range(60));
        end

        // Reset in the middle of a drain must abort without a clock edge
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_word  = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset", {27'd0, bus.in_ready, bus.out_valid, bus.busy, bus.out_last, 1'b0}, 32'b10000);
        chk("async_reset_idx", 32'(bus.out_idx), 32'd0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);

        for (int a = 0; a < 32; a++) begin
            logic [31:0] dec;
            dec = 32'd1 << a;
            do_word(dec, 0, 30);
        end
`ifdef ENCODER_ONEHOT_CHECK_EN
        chk("onehot_clean", 32'(onehot_err), 32'd0);
        do_word(32'h0000_0003, 0, 0);
        chk("onehot_set", 32'(onehot_err), 32'd1);
        do_word(32'h0000_0004, 0, 0);
        chk("onehot_sticky", 32'(onehot_err), 32'd1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
